fp_d_operand_assembler: RTL
===========================

// Module: fp_d_operand_assembler
// PURPOSE
//  Upstream stage of the double-precision sign-injection unit on the 32-bit datapath.
//  Collects two 64-bit operands as four 32-bit beats over a valid/ready bus.
//  Presents them, with the 2-bit sign-injection op, as one 64-bit a/b/op transaction.
//  Downstream stage is combinational; it consumes out_a/out_b/out_op while out_valid=1.
// PARAMETERS
//  BEAT_W  32  width of one input beat; operand width is 2*BEAT_W (64)
//  OP_W    2   op field width; 00/01=FSGNJ, 10=FSGNJN, 11=FSGNJX, passed through unchanged
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  flush      in   1         synchronous abort of any partial or pending transaction
//  in_valid   in   1         in_data/in_op valid this cycle
//  in_ready   out  1         block accepts a beat this cycle
//  in_data    in   BEAT_W    beat payload, order: a[31:0], a[63:32], b[31:0], b[63:32]
//  in_op      in   OP_W      op; sampled only on the first beat (a low half)
//  out_valid  out  1         assembled transaction available
//  out_ready  in   1         downstream accepts the transaction
//  out_a      out  2*BEAT_W  operand a
//  out_b      out  2*BEAT_W  operand b (sign source)
//  out_op     out  OP_W      op captured with the first beat
//  busy       out  1         1 when state != S_A_LO (partial or pending transaction)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_A_LO, out_a=0, out_b=0, out_op=0.
//    out_valid=0, in_ready=1, busy=0. Deasserting reset leaves the block idle in S_A_LO.
//  - FSM: S_A_LO -> S_A_HI -> S_B_LO -> S_B_HI -> S_OUT -> S_A_LO.
//    A collect state advances only on a beat (in_valid & in_ready). Otherwise it holds.
//  - Beat writes:
//    S_A_LO: out_a[31:0] <= in_data, out_op <= in_op.
//    S_A_HI: out_a[63:32] <= in_data.
//    S_B_LO: out_b[31:0] <= in_data.
//    S_B_HI: out_b[63:32] <= in_data.
//  - in_ready=1 in all collect states, 0 in S_OUT. It is a pure decode of state; no comb path from in_valid.
//  - out_valid=1 exactly in S_OUT, decoded from the registered state.
//    First out_valid comes the cycle after the 4th beat. Minimum period is 5 cycles per transaction.
//  - S_OUT -> S_A_LO when out_ready=1. out_valid may be held any number of cycles.
//    While held, out_a/out_b/out_op stay constant.
//  - out_* registers change only on accepted beats or reset. They are not cleared after handoff.
//  - in_valid=0 mid-transaction (bubble): state and captured halves hold indefinitely.
//  - flush=1 (sampled at clk): next state=S_A_LO from any state. Priority over beats and out_ready.
//    A beat presented in the flush cycle is not captured; its handshake still completes (in_ready=1) and the beat is lost.
//    out_* data registers keep their values; out_valid=0 from the next cycle.
//  - Reset asserted mid-transaction: async return to reset values; partial operands discarded.
//  - No width arithmetic; bit 63 of each operand is its sign, passed unmodified.
// TESTING
//  1) Reset, then beats 0x00000000,0x3FF00000,0x00000000,0xC0000000 with op=01 and out_ready=1.
//     -> out_valid high cycle 5, out_a=0x3FF0000000000000, out_b=0xC000000000000000, out_op=01.
//  2) As 1, but out_ready=0 for 3 cycles.
//     -> out_valid stays 1, outputs stable, in_ready=0 throughout; accepted on cycle out_ready=1.
//  3) Bubbles: in_valid=0 for 2 cycles after each beat.
//     -> same result as 1; busy=1 from the first beat until handoff.
//  4) flush with the 3rd beat (S_B_LO).
//     -> next cycle state S_A_LO, busy=0. A fresh 4-beat op=11 with a=0x8000000000000001, b=0x8000000000000000 presents those exact values.
//  5) rst_n low while in S_OUT.
//     -> out_valid=0, out_a=out_b=0, in_ready=1 immediately (async), no handshake completes.
//  6) Back-to-back: 3 transactions with in_valid=1 and out_ready=1 continuously.
//     -> out_valid pulses every 5 cycles; op order and payloads preserved.

Source files
------------

// File: rtl/fp_d_operand_assembler.sv
// ---------------------------------------------------------------------------
// fp_d_operand_assembler
//   Front end of the double-precision sign-injection unit on the 32-bit
//   datapath. Gathers two 64-bit operands as four BEAT_W-wide beats
//   (a lo, a hi, b lo, b hi) over a valid/ready bus and presents them, along
//   with the sign-injection op captured on the first beat, as a single
//   a/b/op transaction held until the downstream stage accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any partial or pending transaction
//   in_valid   beat present on in_data/in_op
//   in_ready   block can accept a beat (all collect states)
//   in_data    beat payload
//   in_op      sign-injection op, sampled on the a-low beat only
//   out_valid  assembled transaction available
//   out_ready  downstream accepts the transaction
//   out_a      operand a
//   out_b      operand b (sign source)
//   out_op     op captured with the first beat
//   busy       partial or pending transaction in flight
// ---------------------------------------------------------------------------
module fp_d_operand_assembler #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned OP_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BEAT_W-1:0]   in_data,
  input  logic [OP_W-1:0]     in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*BEAT_W-1:0] out_a,
  output logic [2*BEAT_W-1:0] out_b,
  output logic [OP_W-1:0]     out_op,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_A_LO,
    S_A_HI,
    S_B_LO,
    S_B_HI,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nx;
  logic   beat;

  assign beat = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A_LO;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready is a pure decode of state so there is no combinational path
  // from in_valid back to in_ready.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_A_LO: begin
        busy = 1'b0;
        if (beat) state_nx = S_A_HI;
      end
      S_A_HI: if (beat) state_nx = S_B_LO;
      S_B_LO: if (beat) state_nx = S_B_HI;
      S_B_HI: if (beat) state_nx = S_OUT;
      S_OUT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nx = S_A_LO;
      end
      default: state_nx = S_A_LO;
    endcase
    // Flush wins over beats and out_ready; a beat offered in the same cycle
    // still handshakes but is dropped.
    if (flush) state_nx = S_A_LO;
  end

  // Output registers double as the capture buffer; they only move on an
  // accepted, non-flushed beat and are left intact after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a  <= '0;
      out_b  <= '0;
      out_op <= '0;
    end else if (beat && !flush) begin
      unique case (state)
        S_A_LO: begin
          out_a[BEAT_W-1:0] <= in_data;
          out_op            <= in_op;
        end
        S_A_HI:  out_a[2*BEAT_W-1:BEAT_W] <= in_data;
        S_B_LO:  out_b[BEAT_W-1:0]        <= in_data;
        S_B_HI:  out_b[2*BEAT_W-1:BEAT_W] <= in_data;
        default: ;
      endcase
    end
  end

endmodule
